countdown_timer_bcd: RTL and testbench

- Parametrised successor to the single-purpose seconds countdown.
- Holds a 4-digit BCD down-counter that decrements once per tick. The tick comes from an internal prescaler derived from CLK_HZ/TICK_HZ.
- Supports load, start, pause/resume, optional auto-reload and a one-cycle expiry pulse.
- Drives the Basys-style 4-digit multiplexed 7-segment display directly.
- Sits between switch/button front-end logic and any module that needs a timed trigger.

---
 rtl/countdown_timer_bcd_pkg.sv | 47 ++++
 rtl/countdown_timer_bcd_seg_scan4.sv | 62 ++++++
 rtl/countdown_timer_bcd.sv | 164 ++++++++++++++++
 tb/tb_countdown_timer_bcd.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_bcd_pkg.sv
// Shared types and helpers for the BCD countdown timer: FSM state encoding,
// active-low 7-segment patterns and BCD digit utilities.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_seg_scan4.sv
// Four-digit multiplexed 7-segment driver: walks the digits at a fixed rate
// and presents registered, active-low segment/decimal-point/anode signals.
module seg_scan4
    import countdown_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] bcd,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    digit_val;

    assign digit_val = bcd[{digit_q, 2'b00} +: 4];

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
        seg_d = blank_mask[digit_q] ? SEG_BLANK : seg_decode(digit_val);
        dp_d  = ~dp_mask[digit_q];
        an_d  = ~(4'b0001 << digit_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= 4'b1111;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: rtl/countdown_timer_bcd.sv
// Four-digit BCD countdown timer with prescaled tick, pause/resume,
// optional auto-reload, expiry pulse and a direct 7-segment display drive.
module countdown_timer_bcd
    import countdown_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        start,
    input  logic        pause,
    input  logic        auto_reload,
    output logic        busy,
    output logic        done,
    output logic        expired,
    output logic [15:0] count_bcd,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   reload_q, reload_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;

    logic [15:0]   load_clamped;
    logic [15:0]   count_dec;
    logic [3:0]    borrow;
    logic [3:0]    blank_mask;
    logic [3:0]    dp_mask;
    logic          tick;

    assign borrow[0]     = 1'b1;
    assign blank_mask[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign load_clamped[gi*4 +: 4] = bcd_clamp(load_bcd[gi*4 +: 4]);
            // Ripple borrow: a digit only decrements if every lower digit was 0.
            assign count_dec[gi*4 +: 4] =
                !borrow[gi]                    ? count_q[gi*4 +: 4] :
                (count_q[gi*4 +: 4] == 4'd0)   ? 4'd9 :
                                                 count_q[gi*4 +: 4] - 4'd1;
            if (gi < 3) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & (count_q[gi*4 +: 4] == 4'd0);
            end
            if (gi > 0) begin : g_blank
                assign blank_mask[gi] = (BLANK_LZ != 0) && (count_q[15:gi*4] == '0);
            end
        end
    endgenerate

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_clamped;
            reload_d = load_clamped;
            presc_d  = '0;
            state_d  = ST_IDLE;
        end else if (state_q == ST_RUN) begin
            // The pause cycle itself still counts as a running cycle.
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (count_q == 16'h0000) begin
                    if (reload_q != 16'h0000) begin
                        count_d = reload_q;
                    end else begin
                        state_d = ST_EXPIRED;
                    end
                end else begin
                    count_d = count_dec;
                    if (count_q == 16'h0001) begin
                        done_d = 1'b1;
                        if (!(auto_reload && (reload_q != 16'h0000))) begin
                            state_d = ST_EXPIRED;
                        end
                    end
                end
            end
            if (pause && (state_d == ST_RUN)) begin
                state_d = ST_PAUSED;
            end
        end else if (start && !pause) begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (count_q != 16'h0000) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end
                end
                // Resume keeps the partial tick; PAUSED at 0000 can only be the
                // auto-reload gap, so resuming there is still meaningful.
                ST_PAUSED: state_d = ST_RUN;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        dp_mask = 4'b0000;
        if (state_q == ST_PAUSED) begin
            dp_mask = 4'b0001;
        end else if (state_q == ST_EXPIRED) begin
            dp_mask = 4'b1111;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign expired   = (state_q == ST_EXPIRED);
    assign done      = done_q;
    assign count_bcd = count_q;

    seg_scan4 #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clock      (clock),
        .resetn     (resetn),
        .bcd        (count_q),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd: stimulus queues expected count
// changes and done pulses; a negedge monitor pops and compares them.
module tb_countdown_timer_bcd;

    logic        clock;
    logic        resetn;
    logic        load;
    logic [15:0] load_bcd;
    logic        start;
    logic        pause;
    logic        auto_reload;
    logic        busy;
    logic        done;
    logic        expired;
    logic [15:0] count_bcd;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    countdown_timer_bcd #(
        .CLK_HZ   (100),
        .TICK_HZ  (10),
        .SCAN_HZ  (50),
        .BLANK_LZ (1)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .load        (load),
        .load_bcd    (load_bcd),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .busy        (busy),
        .done        (done),
        .expired     (expired),
        .count_bcd   (count_bcd),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          c;
        logic [15:0] v;
    } exp_t;

    exp_t        cnt_q[$];
    int          done_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] prev_cnt = 16'h0000;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every count change and every done-high cycle must match the
    // next queued expectation, both in value and in the edge it happened on.
    always @(negedge clock) begin
        exp_t x;
        int   dc;
        if (resetn) begin
            if (count_bcd !== prev_cnt) begin
                n_vec++;
                if (cnt_q.size() == 0) begin
                    n_err++;
                    $display("FAIL count_event: got %h at cycle %0d, required no change", count_bcd, cyc);
                end else begin
                    x = cnt_q.pop_front();
                    if (x.v !== count_bcd || x.c != cyc) begin
                        n_err++;
                        $display("FAIL count_event: got %h at cycle %0d, required %h at cycle %0d",
                                 count_bcd, cyc, x.v, x.c);
                    end else begin
                        $display("count -> %h at cycle %0d ok", count_bcd, cyc);
                    end
                end
            end
            if (done === 1'b1) begin
                n_vec++;
                if (done_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_event: got pulse at cycle %0d, required none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    if (dc != cyc) begin
                        n_err++;
                        $display("FAIL done_event: got pulse at cycle %0d, required cycle %0d", cyc, dc);
                    end else begin
                        $display("done pulse at cycle %0d ok", cyc);
                    end
                end
            end
        end
        prev_cnt <= count_bcd;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("%s = %h ok", name, got);
        end
    endtask

    task automatic push_cnt(input int c, input logic [15:0] v);
        exp_t x;
        x.c = c;
        x.v = v;
        cnt_q.push_back(x);
    endtask

    // Caller is at a negedge; inputs are sampled on the next posedge (cycle e).
    task automatic pulse(input logic l, input logic [15:0] v, input logic s,
                         input logic p, output int e);
        load     = l;
        load_bcd = v;
        start    = s;
        pause    = p;
        e        = cyc + 1;
        @(negedge clock);
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e;
        int          s;
        int          r;
        int          k;
        logic [3:0]  pa;
        logic [3:0]  exp_an [4];
        logic [6:0]  exp_seg [4];

        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h24, 7'h19, 7'h7F, 7'h7F};

        resetn = 1'b0; load = 1'b0; load_bcd = 16'h0; start = 1'b0;
        pause = 1'b0; auto_reload = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_count",   count_bcd, 16'h0000);
        chk("rst_busy",    busy, 1'b0);
        chk("rst_done",    done, 1'b0);
        chk("rst_expired", expired, 1'b0);
        chk("rst_an",      an, 4'b1111);
        chk("rst_seg",     seg, 7'h7F);
        chk("rst_dp",      dp, 1'b1);
        resetn = 1'b1;
        @(negedge clock);

        // 0003 counts down to 0000 and expires.
        push_cnt(cyc + 1, 16'h0003);
        pulse(1'b1, 16'h0003, 1'b0, 1'b0, e);
        pulse(1'b0, 16'h0000, 1'b1, 1'b0, s);
        push_cnt(s + 10, 16'h0002);
        push_cnt(s + 20, 16'h0001);
        push_cnt(s + 30, 16'h0000);
        done_q.push_back(s + 30);
        wait_to(s + 5);
        chk("run_busy", busy, 1'b1);
        wait_to(s + 32);
        chk("exp_expired", expired, 1'b1);
        chk("exp_busy",    busy, 1'b0);
        chk("exp_dp_all",  dp, 1'b0);

        // Borrow chain and clamping.
        push_cnt(cyc + 1, 16'h0100);
        pulse(1'b1, 16'h0100, 1'b0, 1'b0, e);
        pulse(1'b0, 16'h0000, 1'b1, 1'b0, s);
        push_cnt(s + 10, 16'h0099);
        wait_to(s + 12);
        push_cnt(cyc + 1, 16'h9959);
        pulse(1'b1, 16'hFA5C, 1'b0, 1'b0, e);
        chk("clamp_idle_busy", busy, 1'b0);

        // Pause mid-tick and resume.
        push_cnt(cyc + 1, 16'h0005);
        pulse(1'b1, 16'h0005, 1'b0, 1'b0, e);
        pulse(1'b0, 16'h0000, 1'b1, 1'b0, s);
        push_cnt(s + 10, 16'h0004);
        wait_to(s + 12);
        pulse(1'b0, 16'h0000, 1'b0, 1'b1, e);
        wait_to(s + 30);
        chk("pause_busy",  busy, 1'b0);
        chk("pause_count", count_bcd, 16'h0004);
        for (int i = 0; i < 8; i++) begin
            chk("pause_dp", dp, (an == 4'b1110) ? 1'b0 : 1'b1);
            @(negedge clock);
        end
        wait_to(s + 63);
        chk("pause_count_end", count_bcd, 16'h0004);
        pulse(1'b0, 16'h0000, 1'b1, 1'b0, r);
        push_cnt(r + 7, 16'h0003);
        wait_to(r + 8);

        // Auto-reload: 0000 shows for one tick, then reload.
        auto_reload = 1'b1;
        push_cnt(cyc + 1, 16'h0002);
        pulse(1'b1, 16'h0002, 1'b0, 1'b0, e);
        pulse(1'b0, 16'h0000, 1'b1, 1'b0, s);
        push_cnt(s + 10, 16'h0001);
        push_cnt(s + 20, 16'h0000);
        done_q.push_back(s + 20);
        push_cnt(s + 30, 16'h0002);
        push_cnt(s + 40, 16'h0001);
        push_cnt(s + 50, 16'h0000);
        done_q.push_back(s + 50);
        wait_to(s + 25);
        chk("reload_busy_a", busy, 1'b1);
        wait_to(s + 51);
        chk("reload_busy_b", busy, 1'b1);
        chk("reload_expired", expired, 1'b0);
        auto_reload = 1'b0;
        pulse(1'b1, 16'h0000, 1'b0, 1'b0, e);

        // Start at 0000 expires immediately.
        done_q.push_back(cyc + 1);
        pulse(1'b0, 16'h0000, 1'b1, 1'b0, s);
        chk("zero_expired", expired, 1'b1);
        chk("zero_busy",    busy, 1'b0);

        // load beats pause and start in the same cycle.
        push_cnt(cyc + 1, 16'h0007);
        pulse(1'b1, 16'h0007, 1'b1, 1'b1, e);
        chk("prio_busy",    busy, 1'b0);
        chk("prio_expired", expired, 1'b0);
        repeat (12) @(negedge clock);
        chk("prio_count",   count_bcd, 16'h0007);

        // Display scan of 0042 with leading-zero blanking.
        push_cnt(cyc + 1, 16'h0042);
        pulse(1'b1, 16'h0042, 1'b0, 1'b0, e);
        pa = an;
        @(negedge clock);
        k = 0;
        while (k < 12 && !(an == 4'b1110 && pa != 4'b1110)) begin
            pa = an;
            @(negedge clock);
            k++;
        end
        chk("scan_align", an, 4'b1110);
        for (int d = 0; d < 4; d++) begin
            for (int h = 0; h < 2; h++) begin
                chk("scan_an",  an,  exp_an[d]);
                chk("scan_seg", seg, exp_seg[d]);
                chk("scan_dp",  dp,  1'b1);
                @(negedge clock);
            end
        end
        chk("scan_wrap", an, 4'b1110);

        // Asynchronous reset mid-scan.
        k = 0;
        while (k < 12 && an != 4'b1101) begin
            @(negedge clock);
            k++;
        end
        #2 resetn = 1'b0;
        #1;
        chk("async_an",    an, 4'b1111);
        chk("async_seg",   seg, 7'h7F);
        chk("async_count", count_bcd, 16'h0000);
        repeat (2) @(negedge clock);
        chk("async_hold_an", an, 4'b1111);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        chk("cnt_queue_left",  cnt_q.size(), 0);
        chk("done_queue_left", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
